// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_pkg : shared widths, NOP encoding, FSM states, IF/ID record
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_fetch_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg : 33-bit IF/ID pipeline register with load, hold and flush-to-NOP
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t r_q;

  // Flush wins over load; with neither asserted the register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= IF_ID_BUBBLE;
    end else if (flush_i) begin
      r_q <= IF_ID_BUBBLE;
    end else if (load_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit : PC register, boot delay, stall/bubble/redirect fetch control
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_STEP     = 16'd1,
  parameter int unsigned       BOOT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               mem_conflict,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               redirect_pending
);

  localparam logic [3:0] C_BOOT_INIT = 4'(BOOT_CYCLES);

  fetch_state_e      state_q, state_d;
  logic [3:0]        boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              pending_q, pending_d;
  logic              ifid_load, ifid_flush;
  if_id_t            ifid_d, ifid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= C_BOOT_INIT;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    target_d   = target_q;
    pending_d  = pending_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{pc: pc_q, instr: instr_in, valid: 1'b1};

    case (state_q)
      ST_BOOT: begin
        ifid_flush = 1'b1;
        if (boot_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (stall) begin
          // Load-use hazard: everything freezes, branch_taken is ignored.
        end else if (mem_conflict) begin
          // The delay slot at pc_q is still unfetched, so the target waits.
          ifid_flush = 1'b1;
          if (branch_taken) begin
            target_d  = branch_target;
            pending_d = 1'b1;
          end
        end else if (pending_q) begin
          ifid_load = 1'b1;
          pc_d      = target_q;
          pending_d = 1'b0;
        end else if (branch_taken) begin
          ifid_load = 1'b1;
          pc_d      = branch_target;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_q + PC_STEP;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign pc_out           = pc_q;
  assign if_id_pc         = ifid_q.pc;
  assign if_id_instr      = ifid_q.instr;
  assign if_id_valid      = ifid_q.valid;
  assign redirect_pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit : directed table-driven bench for pc_fetch_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        stall, mem_conflict, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc_out, if_id_pc, if_id_instr;
  logic        if_id_valid, redirect_pending;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address A holds A + 16'h1000.
  assign instr_in = pc_out + 16'h1000;

  pc_fetch_unit #(
    .RESET_PC    (16'h0000),
    .PC_STEP     (16'd1),
    .BOOT_CYCLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_in         (instr_in),
    .stall            (stall),
    .mem_conflict     (mem_conflict),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .pc_out           (pc_out),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid),
    .redirect_pending (redirect_pending)
  );

  typedef struct {
    logic        st;
    logic        mc;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        ck_ifpc;
    logic [15:0] e_ifpc;
    logic [15:0] e_instr;
    logic        e_valid;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic ck_ifpc,
                         input logic [15:0] e_ifpc, input logic [15:0] e_instr,
                         input logic e_valid, input logic e_pend);
    chk({tag, " pc_out"}, pc_out, e_pc);
    if (ck_ifpc) chk({tag, " if_id_pc"}, if_id_pc, e_ifpc);
    chk({tag, " if_id_instr"}, if_id_instr, e_instr);
    chk({tag, " if_id_valid"}, 16'(if_id_valid), 16'(e_valid));
    chk({tag, " redirect_pending"}, 16'(redirect_pending), 16'(e_pend));
  endtask

  function automatic vec_t mk(logic st, logic mc, logic br, logic [15:0] tgt,
                              logic [15:0] e_pc, logic ck, logic [15:0] e_ifpc,
                              logic [15:0] e_instr, logic e_valid, logic e_pend);
    vec_t v;
    v.st = st; v.mc = mc; v.br = br; v.tgt = tgt; v.e_pc = e_pc; v.ck_ifpc = ck;
    v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic drive(input logic st, input logic mc, input logic br, input logic [15:0] tgt);
    stall = st; mem_conflict = mc; branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    // Boot: two bubbles, then sequential fetch from 0.
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0000, 0,16'h0000, 16'h0800, 0, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0000, 0,16'h0000, 16'h0800, 0, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0001, 1,16'h0000, 16'h1000, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0002, 1,16'h0001, 16'h1001, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0003, 1,16'h0002, 16'h1002, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0004, 1,16'h0003, 16'h1003, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0005, 1,16'h0004, 16'h1004, 1, 0));
    // One-cycle memory conflict at pc 5.
    vecs.push_back(mk(0,1,0,16'h0000, 16'h0005, 0,16'h0000, 16'h0800, 0, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0006, 1,16'h0005, 16'h1005, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0007, 1,16'h0006, 16'h1006, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0008, 1,16'h0007, 16'h1007, 1, 0));
    // Three-cycle stall at pc 8.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,0,16'h0000, 16'h0008, 1,16'h0007, 16'h1007, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0009, 1,16'h0008, 16'h1008, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h000A, 1,16'h0009, 16'h1009, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h000B, 1,16'h000A, 16'h100A, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h000C, 1,16'h000B, 16'h100B, 1, 0));
    // Taken branch at pc 12 to 0x40, delay slot captured.
    vecs.push_back(mk(0,0,1,16'h0040, 16'h0040, 1,16'h000C, 16'h100C, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0041, 1,16'h0040, 16'h1040, 1, 0));
    // Branch under stall is ignored.
    vecs.push_back(mk(1,0,1,16'h0100, 16'h0041, 1,16'h0040, 16'h1040, 1, 0));
    vecs.push_back(mk(0,0,1,16'h0014, 16'h0014, 1,16'h0041, 16'h1041, 1, 0));
    // Branch during 2-cycle conflict at pc 20, plus a stall while pending.
    vecs.push_back(mk(0,1,1,16'h0020, 16'h0014, 0,16'h0000, 16'h0800, 0, 1));
    vecs.push_back(mk(0,1,0,16'h0000, 16'h0014, 0,16'h0000, 16'h0800, 0, 1));
    vecs.push_back(mk(1,0,0,16'h0000, 16'h0014, 0,16'h0000, 16'h0800, 0, 1));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0020, 1,16'h0014, 16'h1014, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0021, 1,16'h0020, 16'h1020, 1, 0));
    // Wrap at 0xFFFF.
    vecs.push_back(mk(0,0,1,16'hFFFE, 16'hFFFE, 1,16'h0021, 16'h1021, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'hFFFF, 1,16'hFFFE, 16'h0FFE, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0000, 1,16'hFFFF, 16'h0FFF, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0001, 1,16'h0000, 16'h1000, 1, 0));
    // Stall and conflict together: stall wins.
    vecs.push_back(mk(1,1,0,16'h0000, 16'h0001, 1,16'h0000, 16'h1000, 1, 0));
    vecs.push_back(mk(0,0,0,16'h0000, 16'h0002, 1,16'h0001, 16'h1001, 1, 0));

    rst = 1'b0;
    drive(0, 0, 0, 16'h0000);
    #12;
    chk_all("reset", 16'h0000, 1, 16'h0000, 16'h0800, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].mc, vecs[i].br, vecs[i].tgt);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].ck_ifpc, vecs[i].e_ifpc,
              vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_pend);
    end

    // Asynchronous reset mid-cycle while a redirect is pending.
    drive(0, 1, 1, 16'h0300);
    @(posedge clk); #1;
    chk("pend set", 16'(redirect_pending), 16'h0001);
    drive(0, 0, 0, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async rst", 16'h0000, 1, 16'h0000, 16'h0800, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("reboot1", 16'h0000, 1, 16'h0000, 16'h0800, 0, 0);
    @(posedge clk); #1;
    chk_all("reboot2", 16'h0000, 1, 16'h0000, 16'h0800, 0, 0);
    @(posedge clk); #1;
    chk_all("reboot fetch", 16'h0001, 1, 16'h0000, 16'h1000, 1, 0);
    @(posedge clk); #1;
    chk_all("target lost", 16'h0002, 1, 16'h0001, 16'h1001, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
